// File: rtl/regfile_wb_scheduler_pkg.sv
// rtl/regfile_wb_scheduler_pkg.sv - shared constants and helpers for the write-back scheduler
package regfile_wb_scheduler_pkg;

    typedef enum logic [1:0] {
        WR_NONE = 2'b00,
        WR_LINK = 2'b01,
        WR_R1   = 2'b10,
        WR_R2   = 2'b11
    } wr_code_e;

    typedef enum logic [1:0] {
        REQ_ALU  = 2'd0,
        REQ_LD   = 2'd1,
        REQ_LINK = 2'd2
    } req_id_e;

    localparam int NUM_REQ      = 3;
    localparam int LINK_IDX_DEF = 31;

    // Requester slot reached by stepping k places from p, wrapping modulo 3.
    function automatic logic [1:0] rr_slot(input logic [1:0] p, input int k);
        int s;
        s = int'(p) + k;
        if (s >= NUM_REQ) begin
            s = s - NUM_REQ;
        end
        return s[1:0];
    endfunction

endpackage

// File: rtl/regfile_wb_scheduler_if.sv
// rtl/regfile_wb_scheduler_if.sv - requester-side write-back request bus
interface regfile_wb_scheduler_if #(
    parameter int DATA_W = 32,
    parameter int IDX_W  = 5
);
    logic [2:0]          req_valid;
    logic [2:0]          req_ready;
    logic [3*IDX_W-1:0]  req_idx;
    logic [3*DATA_W-1:0] req_data;

    modport master (
        output req_valid,
        output req_idx,
        output req_data,
        input  req_ready
    );

    modport slave (
        input  req_valid,
        input  req_idx,
        input  req_data,
        output req_ready
    );
endinterface

// File: rtl/regfile_wb_scheduler_rr_arbiter3.sv
// rtl/regfile_wb_scheduler_rr_arbiter3.sv - three-way round-robin arbiter with one-hot grant
module rr_arbiter3
    import regfile_wb_scheduler_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [2:0] req,
    output logic [2:0] grant,
    output logic       grant_valid,
    output logic [1:0] grant_id
);

    logic [1:0] rr_ptr;

    // Nothing is granted while reset is held, so requests in that window are dropped.
    always_comb begin
        grant       = '0;
        grant_valid = 1'b0;
        grant_id    = REQ_ALU;
        if (!rst) begin
            for (int k = 0; k < NUM_REQ; k++) begin
                if (!grant_valid && req[rr_slot(rr_ptr, k)]) begin
                    grant_valid = 1'b1;
                    grant_id    = rr_slot(rr_ptr, k);
                end
            end
            if (grant_valid) begin
                grant[grant_id] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr <= 2'd0;
        end else if (grant_valid) begin
            rr_ptr <= rr_slot(grant_id, 1);
        end
    end

endmodule

// File: rtl/regfile_wb_scheduler.sv
// rtl/regfile_wb_scheduler.sv - register-file write-port arbiter with pending-write scoreboard
module regfile_wb_scheduler
    import regfile_wb_scheduler_pkg::*;
#(
    parameter int DATA_W   = 32,
    parameter int IDX_W    = 5,
    parameter int LINK_IDX = LINK_IDX_DEF
) (
    input  logic              clk,
    input  logic              rst,
    regfile_wb_scheduler_if.slave req,
    output logic [1:0]        wr_code,
    output logic [IDX_W-1:0]  wr_idx,
    output logic [DATA_W-1:0] wr_data,
    input  logic              rsv_valid,
    input  logic [IDX_W-1:0]  rsv_idx,
    input  logic [IDX_W-1:0]  src_a_idx,
    input  logic [IDX_W-1:0]  src_b_idx,
    output logic              src_a_busy,
    output logic              src_b_busy,
    output logic              err_double_rsv
);

    localparam int NREG = 1 << IDX_W;

    logic [2:0]        grant;
    logic              grant_valid;
    logic [1:0]        grant_id;
    logic [IDX_W-1:0]  sel_idx;
    logic [DATA_W-1:0] sel_data;
    logic [NREG-1:0]   pending;
    logic [NREG-1:0]   pending_next;
    logic              wr_active;
    logic              double_rsv;

    rr_arbiter3 u_arb (
        .clk         (clk),
        .rst         (rst),
        .req         (req.req_valid),
        .grant       (grant),
        .grant_valid (grant_valid),
        .grant_id    (grant_id)
    );

    assign req.req_ready = grant;

    assign sel_idx  = req.req_idx[grant_id*IDX_W +: IDX_W];
    assign sel_data = req.req_data[grant_id*DATA_W +: DATA_W];

    // Index and data hold across idle cycles; only the code drops to none.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_code <= WR_NONE;
            wr_idx  <= '0;
            wr_data <= '0;
        end else if (grant_valid) begin
            if (grant_id == REQ_LINK) begin
                wr_code <= WR_LINK;
                wr_idx  <= IDX_W'(LINK_IDX);
            end else begin
                wr_code <= WR_R1;
                wr_idx  <= sel_idx;
            end
            wr_data <= sel_data;
        end else begin
            wr_code <= WR_NONE;
        end
    end

    assign wr_active = (wr_code != WR_NONE);

    // Clear first, then set, so a reservation landing on the retiring index survives.
    always_comb begin
        pending_next = pending;
        if (wr_active) begin
            pending_next[wr_idx] = 1'b0;
        end
        if (rsv_valid) begin
            pending_next[rsv_idx] = 1'b1;
        end
    end

    assign double_rsv = rsv_valid && pending[rsv_idx] &&
                        !(wr_active && (wr_idx == rsv_idx));

    always_ff @(posedge clk) begin
        if (rst) begin
            pending        <= '0;
            err_double_rsv <= 1'b0;
        end else begin
            pending <= pending_next;
            if (double_rsv) begin
                err_double_rsv <= 1'b1;
            end
        end
    end

    assign src_a_busy = pending[src_a_idx];
    assign src_b_busy = pending[src_b_idx];

endmodule

// File: tb/tb_regfile_wb_scheduler.sv
// tb/tb_regfile_wb_scheduler.sv - self-checking bench for regfile_wb_scheduler
module tb_regfile_wb_scheduler;

    localparam int DW = 32;
    localparam int IW = 5;

    logic          clk = 1'b0;
    logic          rst;
    logic [1:0]    wr_code;
    logic [IW-1:0] wr_idx;
    logic [DW-1:0] wr_data;
    logic          rsv_valid;
    logic [IW-1:0] rsv_idx, src_a_idx, src_b_idx;
    logic          src_a_busy, src_b_busy, err_double_rsv;

    always #5 clk = ~clk;

    regfile_wb_scheduler_if #(.DATA_W(DW), .IDX_W(IW)) bus ();

    regfile_wb_scheduler #(.DATA_W(DW), .IDX_W(IW), .LINK_IDX(31)) dut (
        .clk            (clk),
        .rst            (rst),
        .req            (bus.slave),
        .wr_code        (wr_code),
        .wr_idx         (wr_idx),
        .wr_data        (wr_data),
        .rsv_valid      (rsv_valid),
        .rsv_idx        (rsv_idx),
        .src_a_idx      (src_a_idx),
        .src_b_idx      (src_b_idx),
        .src_a_busy     (src_a_busy),
        .src_b_busy     (src_b_busy),
        .err_double_rsv (err_double_rsv)
    );

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference model: pointer as an integer, scoreboard as a bit array.
    int          m_ptr;
    bit          m_pend [32];
    bit          m_err;
    int          m_code;
    int          m_idx;
    logic [31:0] m_data;
    bit          m_ok = 1'b0;
    int          m_last_g = -1;

    function automatic int m_grant();
        if (rst) return -1;
        for (int k = 0; k < 3; k++) begin
            if (bus.req_valid[(m_ptr + k) % 3]) return (m_ptr + k) % 3;
        end
        return -1;
    endfunction

    task automatic model_check();
        int g;
        if (!m_ok) return;
        g = m_grant();
        chk("model_ready", bus.req_ready, (g < 0) ? 0 : (1 << g));
        chk("model_code", wr_code, m_code);
        chk("model_idx", wr_idx, m_idx);
        chk("model_data", wr_data, m_data);
        chk("model_busy_a", src_a_busy, m_pend[src_a_idx]);
        chk("model_busy_b", src_b_busy, m_pend[src_b_idx]);
        chk("model_err", err_double_rsv, m_err);
    endtask

    task automatic model_advance();
        int g;
        bit clearing;
        int cidx;
        g = m_grant();
        m_last_g = g;
        if (rst) begin
            m_ptr = 0; m_err = 0; m_code = 0; m_idx = 0; m_data = 0; m_ok = 1;
            foreach (m_pend[i]) m_pend[i] = 0;
        end else begin
            clearing = (m_code != 0);
            cidx = m_idx;
            if (rsv_valid && m_pend[rsv_idx] && !(clearing && cidx == int'(rsv_idx))) m_err = 1;
            if (clearing) m_pend[cidx] = 0;
            if (rsv_valid) m_pend[rsv_idx] = 1;
            if (g >= 0) begin
                m_code = (g == 2) ? 1 : 2;
                m_idx  = (g == 2) ? 31 : int'(bus.req_idx[g*IW +: IW]);
                m_data = bus.req_data[g*DW +: DW];
                m_ptr  = (g + 1) % 3;
            end else begin
                m_code = 0;
            end
        end
    endtask

    task automatic cyc_begin();
        @(negedge clk);
        model_check();
    endtask

    task automatic cyc_end();
        model_advance();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            cyc_begin();
            cyc_end();
        end
    endtask

    task automatic clear_inputs();
        bus.req_valid = '0;
        bus.req_idx   = '0;
        bus.req_data  = '0;
        rsv_valid     = 1'b0;
        rsv_idx       = '0;
        src_a_idx     = '0;
        src_b_idx     = '0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        idle(1);
        rst = 1'b0;
    endtask

    typedef struct {
        logic        rst;
        logic [2:0]  valid;
        logic [14:0] idx;
        logic [95:0] data;
        logic [2:0]  exp_ready;
        logic [1:0]  exp_code;
        logic [4:0]  exp_idx;
        logic [31:0] exp_data;
    } vec_t;

    vec_t vt [14];

    initial begin
        logic [14:0] ia, ib;
        logic [95:0] da, db;
        ia = {5'd0, 5'd0, 5'd5};
        da = {32'd0, 32'd0, 32'hDEADBEEF};
        ib = {5'd3, 5'd2, 5'd1};
        db = {32'hC2, 32'hB1, 32'hA0};
        vt[0]  = '{1'b0, 3'b001, ia, da, 3'b001, 2'b00, 5'd0,  32'd0};
        vt[1]  = '{1'b0, 3'b000, ia, da, 3'b000, 2'b10, 5'd5,  32'hDEADBEEF};
        vt[2]  = '{1'b0, 3'b000, ia, da, 3'b000, 2'b00, 5'd5,  32'hDEADBEEF};
        vt[3]  = '{1'b1, 3'b111, ib, db, 3'b000, 2'b00, 5'd5,  32'hDEADBEEF};
        vt[4]  = '{1'b0, 3'b111, ib, db, 3'b001, 2'b00, 5'd0,  32'd0};
        vt[5]  = '{1'b0, 3'b111, ib, db, 3'b010, 2'b10, 5'd1,  32'hA0};
        vt[6]  = '{1'b0, 3'b111, ib, db, 3'b100, 2'b10, 5'd2,  32'hB1};
        vt[7]  = '{1'b0, 3'b111, ib, db, 3'b001, 2'b01, 5'd31, 32'hC2};
        vt[8]  = '{1'b0, 3'b111, ib, db, 3'b010, 2'b10, 5'd1,  32'hA0};
        vt[9]  = '{1'b0, 3'b100, ib, db, 3'b100, 2'b10, 5'd2,  32'hB1};
        vt[10] = '{1'b0, 3'b011, ib, db, 3'b001, 2'b01, 5'd31, 32'hC2};
        vt[11] = '{1'b0, 3'b010, ib, db, 3'b010, 2'b10, 5'd1,  32'hA0};
        vt[12] = '{1'b0, 3'b000, ib, db, 3'b000, 2'b10, 5'd2,  32'hB1};
        vt[13] = '{1'b0, 3'b000, ib, db, 3'b000, 2'b00, 5'd2,  32'hB1};

        rst = 1'b1;
        clear_inputs();
        idle(2);
        rst = 1'b0;

        cyc_begin();
        chk("reset_code", wr_code, 2'b00);
        chk("reset_idx", wr_idx, 5'd0);
        chk("reset_data", wr_data, 32'd0);
        chk("reset_ready", bus.req_ready, 3'b000);
        chk("reset_err", err_double_rsv, 1'b0);
        cyc_end();

        for (int i = 0; i < 14; i++) begin
            rst           = vt[i].rst;
            bus.req_valid = vt[i].valid;
            bus.req_idx   = vt[i].idx;
            bus.req_data  = vt[i].data;
            cyc_begin();
            chk($sformatf("vec%0d_ready", i), bus.req_ready, vt[i].exp_ready);
            chk($sformatf("vec%0d_code", i), wr_code, vt[i].exp_code);
            chk($sformatf("vec%0d_idx", i), wr_idx, vt[i].exp_idx);
            chk($sformatf("vec%0d_data", i), wr_data, vt[i].exp_data);
            cyc_end();
        end
        clear_inputs();
        rst = 1'b0;

        // Scoreboard set and clear around an ALU write of r7.
        do_reset();
        rsv_valid = 1'b1; rsv_idx = 5'd7; src_a_idx = 5'd7; src_b_idx = 5'd9;
        cyc_begin(); chk("sb_no_bypass", src_a_busy, 1'b0); cyc_end();
        rsv_valid = 1'b0;
        cyc_begin(); chk("sb_busy_set", src_a_busy, 1'b1); cyc_end();
        idle(1);
        bus.req_valid = 3'b001; bus.req_idx = {5'd0, 5'd0, 5'd7}; bus.req_data = {64'd0, 32'h1234};
        cyc_begin(); chk("sb_grant", bus.req_ready, 3'b001); chk("sb_busy_grant", src_a_busy, 1'b1); cyc_end();
        bus.req_valid = 3'b000;
        cyc_begin();
        chk("sb_wr_code", wr_code, 2'b10); chk("sb_wr_idx", wr_idx, 5'd7);
        chk("sb_busy_out", src_a_busy, 1'b1);
        cyc_end();
        cyc_begin(); chk("sb_busy_clear", src_a_busy, 1'b0); cyc_end();

        // Reservation of r9 on the same edge its write retires.
        rsv_valid = 1'b1; rsv_idx = 5'd9;
        idle(1);
        rsv_valid = 1'b0;
        bus.req_valid = 3'b001; bus.req_idx = {5'd0, 5'd0, 5'd9};
        idle(1);
        bus.req_valid = 3'b000; rsv_valid = 1'b1; rsv_idx = 5'd9;
        cyc_begin(); chk("sc_wr_idx", wr_idx, 5'd9); chk("sc_busy_before", src_b_busy, 1'b1); cyc_end();
        rsv_valid = 1'b0;
        cyc_begin(); chk("sc_busy_after", src_b_busy, 1'b1); chk("sc_no_err", err_double_rsv, 1'b0); cyc_end();

        // Double reservation of r3 is sticky until reset.
        rsv_valid = 1'b1; rsv_idx = 5'd3; src_a_idx = 5'd3;
        idle(1);
        cyc_begin(); chk("dbl_err_pre", err_double_rsv, 1'b0); cyc_end();
        rsv_valid = 1'b0;
        cyc_begin(); chk("dbl_err_set", err_double_rsv, 1'b1); cyc_end();
        bus.req_valid = 3'b001; bus.req_idx = {5'd0, 5'd0, 5'd3};
        idle(1);
        bus.req_valid = 3'b000;
        idle(3);
        cyc_begin(); chk("dbl_err_sticky", err_double_rsv, 1'b1); chk("dbl_r3_free", src_a_busy, 1'b0); cyc_end();
        do_reset();
        cyc_begin(); chk("dbl_err_rst", err_double_rsv, 1'b0); chk("dbl_busy_rst", src_b_busy, 1'b0); cyc_end();

        // Reset arriving while a load write is on the output.
        rsv_valid = 1'b1; rsv_idx = 5'd4; src_a_idx = 5'd4;
        idle(1);
        rsv_valid = 1'b0;
        bus.req_valid = 3'b010; bus.req_idx = {5'd0, 5'd6, 5'd0}; bus.req_data = {32'd0, 32'h5555, 32'd0};
        cyc_begin(); chk("mf_grant_ld", bus.req_ready, 3'b010); cyc_end();
        rst = 1'b1; bus.req_valid = 3'b111;
        cyc_begin();
        chk("mf_ready_in_rst", bus.req_ready, 3'b000);
        chk("mf_inflight_code", wr_code, 2'b10); chk("mf_inflight_idx", wr_idx, 5'd6);
        cyc_end();
        rst = 1'b0;
        cyc_begin();
        chk("mf_squash", wr_code, 2'b00); chk("mf_busy", src_a_busy, 1'b0);
        chk("mf_ptr0", bus.req_ready, 3'b001);
        cyc_end();
        clear_inputs();

        // Randomized traffic against the reference model.
        do_reset();
        for (int n = 0; n < 2000; n++) begin
            for (int i = 0; i < 3; i++) begin
                if (bus.req_valid[i] && m_last_g != i) begin
                    if ($urandom_range(0, 99) < 15) bus.req_valid[i] = 1'b0;
                end else if ($urandom_range(0, 99) < 45) begin
                    bus.req_valid[i]          = 1'b1;
                    bus.req_idx[i*IW +: IW]   = IW'($urandom_range(0, 7));
                    bus.req_data[i*DW +: DW]  = $urandom;
                end else begin
                    bus.req_valid[i] = 1'b0;
                end
            end
            rst       = ($urandom_range(0, 99) < 2);
            rsv_valid = ($urandom_range(0, 99) < 25);
            rsv_idx   = IW'($urandom_range(0, 7));
            src_a_idx = IW'($urandom_range(0, 7));
            src_b_idx = IW'($urandom_range(0, 31));
            cyc_begin();
            cyc_end();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
